// File: rtl/serial_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_cmd_pkg
// Purpose  : Shared definitions for the serial command engine: opcode values,
//            the engine state encoding and the per-opcode argument count.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package serial_cmd_pkg;

  localparam logic [7:0] OP_VERSION   = 8'd0;
  localparam logic [7:0] OP_CALIB     = 8'd1;
  localparam logic [7:0] OP_HISTSEL   = 8'd2;
  localparam logic [7:0] OP_OUTEN     = 8'd3;
  localparam logic [7:0] OP_CLKSW     = 8'd4;
  localparam logic [7:0] OP_PHASE     = 8'd5;
  localparam logic [7:0] OP_ACTCLK    = 8'd8;
  localparam logic [7:0] OP_UPDOWN    = 8'd9;
  localparam logic [7:0] OP_HISTOS    = 8'd10;
  localparam logic [7:0] OP_DELAYS    = 8'd11;
  localparam logic [7:0] OP_RESETHIST = 8'd13;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARGS      = 3'd1,
    ST_EXEC      = 3'd2,
    ST_TX_LAUNCH = 3'd3,
    ST_TX_WAIT   = 3'd4,
    ST_CLKSW     = 3'd5,
    ST_PHASE     = 3'd6
  } state_t;

  // Number of argument bytes that follow each opcode.
  function automatic logic [1:0] arg_count(input logic [7:0] op);
    case (op)
      OP_CALIB, OP_HISTSEL: arg_count = 2'd1;
      OP_PHASE:             arg_count = 2'd2;
      default:              arg_count = 2'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/pll_phase_stepper.sv
`default_nettype none
// ============================================================================
// Module   : pll_phase_stepper
// Purpose  : Runs a sequence of PLL phase steps. Each step raises phasestep
//            with scanclk low, toggles scanclk every SCAN_HALF cycles, drops
//            phasestep after the 6th toggle and ends after the 8th toggle
//            (scanclk back low). Steps run back to back.
// Ports    : clk, rstn             - clock, async active-low reset
//            start                 - one-cycle launch; latches counter/steps
//            counter[2:0]          - PLL counter select to apply
//            steps[7:0]            - number of steps (0 = select only)
//            busy                  - high while steps are in progress
//            phasecounterselect    - registered counter select
//            phasestep, scanclk    - PLL phase-step interface
// Revision : 1.0 - initial release
// ============================================================================
module pll_phase_stepper #(
  parameter int SCAN_HALF = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic [2:0] counter,
  input  logic [7:0] steps,
  output logic       busy,
  output logic [2:0] phasecounterselect,
  output logic       phasestep,
  output logic       scanclk
);

  localparam int DIV_W = (SCAN_HALF > 1) ? $clog2(SCAN_HALF) : 1;

  logic             busy_q, busy_d;
  logic [2:0]       sel_q, sel_d;
  logic             step_q, step_d;
  logic             sclk_q, sclk_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       tog_q, tog_d;
  logic [7:0]       left_q, left_d;

  always_comb begin
    busy_d = busy_q;
    sel_d  = sel_q;
    step_d = step_q;
    sclk_d = sclk_q;
    div_d  = div_q;
    tog_d  = tog_q;
    left_d = left_q;
    if (start) begin
      sel_d = counter;
      if (steps != 8'd0) begin
        busy_d = 1'b1;
        left_d = steps;
        step_d = 1'b1;
        sclk_d = 1'b0;
        div_d  = '0;
        tog_d  = 4'd0;
      end
    end else if (busy_q) begin
      if (div_q == DIV_W'(SCAN_HALF - 1)) begin
        div_d  = '0;
        sclk_d = ~sclk_q;
        tog_d  = tog_q + 4'd1;
        // tog_q counts toggles already done; this edge is toggle tog_q+1.
        if (tog_q == 4'd5) step_d = 1'b0;
        if (tog_q == 4'd7) begin
          tog_d  = 4'd0;
          left_d = left_q - 8'd1;
          if (left_q == 8'd1) busy_d = 1'b0;
          else                step_d = 1'b1;
        end
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_q <= 1'b0;
      sel_q  <= 3'd0;
      step_q <= 1'b0;
      sclk_q <= 1'b0;
      div_q  <= '0;
      tog_q  <= 4'd0;
      left_q <= 8'd0;
    end else begin
      busy_q <= busy_d;
      sel_q  <= sel_d;
      step_q <= step_d;
      sclk_q <= sclk_d;
      div_q  <= div_d;
      tog_q  <= tog_d;
      left_q <= left_d;
    end
  end

  assign busy               = busy_q;
  assign phasecounterselect = sel_q;
  assign phasestep          = step_q;
  assign scanclk            = sclk_q;

endmodule
`default_nettype wire

// File: rtl/serial_cmd_engine.sv
`default_nettype none
// ============================================================================
// Module   : serial_cmd_engine
// Purpose  : Byte-oriented command processor between the UART and the
//            trigger-board control/monitor logic. Decodes opcodes with up to
//            two argument bytes (with an inter-byte timeout), updates control
//            registers, pulses clkswitch/resethist, runs PLL phase steps and
//            streams responses byte by byte straight from the live inputs.
// Macro    : SERIAL_CMD_CHECKSUM_EN - append an XOR checksum byte to every
//            response (default build: payload bytes only).
// Ports    : clk, rstn                  - clock, async active-low reset
//            rxReady, rxData            - received byte strobe / data
//            txBusy, txStart, txData    - transmitter handshake
//            calibticks, histostosend   - control registers
//            enable_outputs, clkswitch  - output enable / clock-switch pulse
//            phasecounterselect, phaseupdown, phasestep, scanclk - PLL ctl
//            resethist                  - one-cycle histogram clear
//            histos, delaycounter       - packed monitor inputs
//            activeclock                - PLL active input clock
// Revision : 1.0 - initial release
// ============================================================================
module serial_cmd_engine
  import serial_cmd_pkg::*;
#(
  parameter int         NUM_HISTOS   = 8,
  parameter int         HISTO_W      = 32,
  parameter int         NUM_DELAY    = 16,
  parameter int         DELAY_W      = 3,
  parameter logic [7:0] FW_VERSION   = 8'd4,
  parameter int         ARG_TIMEOUT  = 50_000_000,
  parameter int         SCAN_HALF    = 16,
  parameter int         CLKSW_CYCLES = 8
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          rxReady,
  input  logic [7:0]                    rxData,
  input  logic                          txBusy,
  output logic                          txStart,
  output logic [7:0]                    txData,
  output logic [7:0]                    calibticks,
  output logic [7:0]                    histostosend,
  output logic                          enable_outputs,
  output logic                          clkswitch,
  output logic [2:0]                    phasecounterselect,
  output logic                          phaseupdown,
  output logic                          phasestep,
  output logic                          scanclk,
  output logic                          resethist,
  input  logic [NUM_HISTOS*HISTO_W-1:0] histos,
  input  logic [NUM_DELAY*DELAY_W-1:0]  delaycounter,
  input  logic                          activeclock
);

`ifdef SERIAL_CMD_CHECKSUM_EN
  localparam int CK_BYTES = 1;
`else
  localparam int CK_BYTES = 0;
`endif

  localparam int HBYTES    = NUM_HISTOS * HISTO_W / 8;
  localparam int MAX_PAY   = (HBYTES > NUM_DELAY) ? HBYTES : NUM_DELAY;
  localparam int TOTAL_MAX = MAX_PAY + CK_BYTES;
  localparam int IDX_W     = (TOTAL_MAX > 1) ? $clog2(TOTAL_MAX) : 1;
  localparam int TO_W      = $clog2(ARG_TIMEOUT + 1);
  localparam int CSW_W     = (CLKSW_CYCLES > 1) ? $clog2(CLKSW_CYCLES) : 1;

  state_t           state_q, state_d;
  logic [7:0]       op_q, op_d;
  logic [1:0][7:0]  arg_q, arg_d;
  logic [1:0]       argn_q, argn_d;
  logic [TO_W-1:0]  tcnt_q, tcnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       csum_q, csum_d;
  logic [CSW_W-1:0] csw_q, csw_d;
  logic [7:0]       calib_q, calib_d;
  logic [7:0]       hsel_q, hsel_d;
  logic             en_q, en_d;
  logic             cksw_q, cksw_d;
  logic             updown_q, updown_d;
  logic             rsth_q, rsth_d;
  logic             txs_q, txs_d;
  logic [7:0]       txd_q, txd_d;

  logic             ph_start;
  logic             ph_busy;
  int               pay_len;
  int               last_idx;
  int               h_idx;
  int               d_idx;
  logic [7:0]       tx_byte;

  // Response length and the byte selected for the current index. Bytes are
  // taken from the live inputs when launched, never snapshotted.
  always_comb begin
    case (op_q)
      OP_HISTOS: pay_len = HBYTES;
      OP_DELAYS: pay_len = NUM_DELAY;
      default:   pay_len = 1;
    endcase
    last_idx = pay_len + CK_BYTES - 1;
    h_idx    = (int'(idx_q) < HBYTES)    ? int'(idx_q) : 0;
    d_idx    = (int'(idx_q) < NUM_DELAY) ? int'(idx_q) : 0;
    tx_byte  = 8'h00;
    if ((CK_BYTES != 0) && (int'(idx_q) >= pay_len)) begin
      tx_byte = csum_q;
    end else begin
      case (op_q)
        OP_VERSION: tx_byte = FW_VERSION;
        OP_ACTCLK:  tx_byte = {7'b0, activeclock};
        OP_HISTOS:  tx_byte = histos[h_idx*8 +: 8];
        OP_DELAYS:  tx_byte[DELAY_W-1:0] = delaycounter[d_idx*DELAY_W +: DELAY_W];
        default:    tx_byte = 8'h00;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    arg_d    = arg_q;
    argn_d   = argn_q;
    tcnt_d   = tcnt_q;
    idx_d    = idx_q;
    csum_d   = csum_q;
    csw_d    = csw_q;
    calib_d  = calib_q;
    hsel_d   = hsel_q;
    en_d     = en_q;
    cksw_d   = cksw_q;
    updown_d = updown_q;
    rsth_d   = 1'b0;
    txs_d    = 1'b0;
    txd_d    = txd_q;
    ph_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rxReady) begin
          op_d    = rxData;
          argn_d  = 2'd0;
          tcnt_d  = '0;
          state_d = (arg_count(rxData) != 2'd0) ? ST_ARGS : ST_EXEC;
        end
      end
      ST_ARGS: begin
        if (rxReady) begin
          arg_d[argn_q[0]] = rxData;
          argn_d = argn_q + 2'd1;
          tcnt_d = '0;
          if ((argn_q + 2'd1) == arg_count(op_q)) state_d = ST_EXEC;
        end else if (tcnt_q == TO_W'(ARG_TIMEOUT)) begin
          // Abandon the partial command silently.
          tcnt_d  = '0;
          state_d = ST_IDLE;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      ST_EXEC: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        csum_d  = 8'h00;
        case (op_q)
          OP_VERSION, OP_ACTCLK, OP_HISTOS, OP_DELAYS: state_d = ST_TX_LAUNCH;
          OP_CALIB:     calib_d  = arg_q[0];
          OP_HISTSEL:   hsel_d   = arg_q[0];
          OP_OUTEN:     en_d     = ~en_q;
          OP_UPDOWN:    updown_d = ~updown_q;
          OP_RESETHIST: rsth_d   = 1'b1;
          OP_CLKSW: begin
            cksw_d  = 1'b1;
            csw_d   = '0;
            state_d = ST_CLKSW;
          end
          OP_PHASE: begin
            ph_start = 1'b1;
            if (arg_q[1] != 8'd0) state_d = ST_PHASE;
          end
          default: ;
        endcase
      end
      ST_TX_LAUNCH: begin
        if (!txBusy) begin
          txd_d   = tx_byte;
          txs_d   = 1'b1;
          csum_d  = csum_q ^ tx_byte;
          state_d = ST_TX_WAIT;
        end
      end
      ST_TX_WAIT: begin
        // One dead cycle lets the transmitter raise txBusy after txStart.
        if (int'(idx_q) == last_idx) begin
          state_d = ST_IDLE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_TX_LAUNCH;
        end
      end
      ST_CLKSW: begin
        if (csw_q == CSW_W'(CLKSW_CYCLES - 1)) begin
          cksw_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          csw_d = csw_q + 1'b1;
        end
      end
      ST_PHASE: begin
        if (!ph_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      op_q     <= 8'h00;
      arg_q    <= '0;
      argn_q   <= 2'd0;
      tcnt_q   <= '0;
      idx_q    <= '0;
      csum_q   <= 8'h00;
      csw_q    <= '0;
      calib_q  <= 8'd10;
      hsel_q   <= 8'h00;
      en_q     <= 1'b0;
      cksw_q   <= 1'b0;
      updown_q <= 1'b1;
      rsth_q   <= 1'b0;
      txs_q    <= 1'b0;
      txd_q    <= 8'h00;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      arg_q    <= arg_d;
      argn_q   <= argn_d;
      tcnt_q   <= tcnt_d;
      idx_q    <= idx_d;
      csum_q   <= csum_d;
      csw_q    <= csw_d;
      calib_q  <= calib_d;
      hsel_q   <= hsel_d;
      en_q     <= en_d;
      cksw_q   <= cksw_d;
      updown_q <= updown_d;
      rsth_q   <= rsth_d;
      txs_q    <= txs_d;
      txd_q    <= txd_d;
    end
  end

  pll_phase_stepper #(
    .SCAN_HALF (SCAN_HALF)
  ) u_stepper (
    .clk                (clk),
    .rstn               (rstn),
    .start              (ph_start),
    .counter            (arg_q[0][2:0]),
    .steps              (arg_q[1]),
    .busy               (ph_busy),
    .phasecounterselect (phasecounterselect),
    .phasestep          (phasestep),
    .scanclk            (scanclk)
  );

  assign txStart        = txs_q;
  assign txData         = txd_q;
  assign calibticks     = calib_q;
  assign histostosend   = hsel_q;
  assign enable_outputs = en_q;
  assign clkswitch      = cksw_q;
  assign phaseupdown    = updown_q;
  assign resethist      = rsth_q;

endmodule
`default_nettype wire
